// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared definitions for the register-file writeback scheduler: register file
// geometry and the select encoding for the write-port multiplexer.
package regfile_wb_scheduler_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;

    // Which requester currently owns the register-file write port.
    typedef enum logic [1:0] {
        SRC_NONE  = 2'd0,
        SRC_ISSUE = 2'd1,
        SRC_WB0   = 2'd2,
        SRC_WB1   = 2'd3
    } wb_src_t;

endpackage

// File: rtl/regfile_wb_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter. Grants are combinational; the remembered
// winner only flips when a grant is actually issued, so an idle cycle does
// not disturb fairness.
module rr_arbiter2 (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_req0,
    input  logic i_req1,
    output logic o_gnt0,
    output logic o_gnt1
);

    // 1 means unit 1 won most recently, so unit 0 wins the first contention.
    logic r_last_grant;
    logic w_gnt0;
    logic w_gnt1;

    // Single requester wins outright; on contention the previous loser wins.
    always_comb begin
        w_gnt0 = i_req0 && (!i_req1 || r_last_grant);
        w_gnt1 = i_req1 && !w_gnt0;
    end

    assign o_gnt0 = w_gnt0;
    assign o_gnt1 = w_gnt1;

    // Remember the winner of every granted cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last_grant <= 1'b1;
        end else if (w_gnt0 || w_gnt1) begin
            r_last_grant <= w_gnt1;
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register-file writeback scheduler. Owns the single write port, tracks which
// registers still await a long-latency result, stalls issue on RAW/WAW
// hazards and shares the port between the two long-latency units.
module regfile_wb_scheduler
    import regfile_wb_scheduler_pkg::*;
#(
    parameter int MAX_PENDING = 4,
    parameter int CNT_W       = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rs1,
    input  logic [REG_ADDR_W-1:0] issue_rs2,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic                  issue_rd_we,
    input  logic                  issue_long,
    input  logic [XLEN-1:0]       issue_data,
    output logic                  issue_ready,
    input  logic                  wb0_valid,
    input  logic [REG_ADDR_W-1:0] wb0_rd,
    input  logic [XLEN-1:0]       wb0_data,
    output logic                  wb0_grant,
    input  logic                  wb1_valid,
    input  logic [REG_ADDR_W-1:0] wb1_rd,
    input  logic [XLEN-1:0]       wb1_data,
    output logic                  wb1_grant,
    output logic                  rf_write_enable,
    output logic [REG_ADDR_W-1:0] rf_rd_address,
    output logic [XLEN-1:0]       rf_rd_data,
    output logic [CNT_W-1:0]      pending_count,
    output logic                  protocol_error
);

    localparam logic [CNT_W-1:0] PEND_MAX = CNT_W'(MAX_PENDING);

    logic [NUM_REGS-1:0]   r_busy;
    logic [CNT_W-1:0]      r_pend_cnt;
    logic                  r_err;

    logic                  w_gnt0;
    logic                  w_gnt1;
    logic                  w_gnt_any;
    logic [REG_ADDR_W-1:0] w_gnt_rd;
    logic                  w_gnt_rd_busy;
    logic                  w_stall;
    logic                  w_ready;
    logic                  w_short_wr;
    logic                  w_long_set;
    logic                  w_clr;
    logic [NUM_REGS-1:0]   w_set_mask;
    logic [NUM_REGS-1:0]   w_clr_mask;
    wb_src_t               w_src;

    // Requests are masked during reset so nothing is granted while state is
    // being cleared; the units drop their in-flight results anyway.
    rr_arbiter2 u_arb (
        .i_clk  (clock),
        .i_rst  (reset),
        .i_req0 (wb0_valid && !reset),
        .i_req1 (wb1_valid && !reset),
        .o_gnt0 (w_gnt0),
        .o_gnt1 (w_gnt1)
    );

    // Hazard detection against the registered scoreboard only; a completion
    // clearing a register this cycle does not release a dependent issue
    // until the next cycle.
    always_comb begin
        w_gnt_any     = w_gnt0 || w_gnt1;
        w_gnt_rd      = w_gnt1 ? wb1_rd : wb0_rd;
        w_gnt_rd_busy = r_busy[w_gnt_rd];
        w_stall = r_busy[issue_rs1] || r_busy[issue_rs2]
               || (issue_rd_we && r_busy[issue_rd])
               || (issue_long && issue_rd_we && (issue_rd != '0) && (r_pend_cnt == PEND_MAX))
               || ((wb0_valid || wb1_valid) && issue_rd_we && !issue_long);
        w_ready    = issue_valid && !w_stall && !reset;
        w_short_wr = w_ready && issue_rd_we && !issue_long && (issue_rd != '0);
        w_long_set = w_ready && issue_rd_we && issue_long && (issue_rd != '0);
        w_clr      = w_gnt_any && w_gnt_rd_busy;
    end

    // Scoreboard masks; x0 is never allowed to become busy.
    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (w_long_set) begin
            w_set_mask = NUM_REGS'(1) << issue_rd;
        end
        if (w_clr) begin
            w_clr_mask = NUM_REGS'(1) << w_gnt_rd;
        end
        w_set_mask[0] = 1'b0;
    end

    // Write-port source selection: completions first, then short issue writes.
    always_comb begin
        w_src = SRC_NONE;
        if (w_gnt0) begin
            w_src = SRC_WB0;
        end else if (w_gnt1) begin
            w_src = SRC_WB1;
        end else if (w_short_wr) begin
            w_src = SRC_ISSUE;
        end
    end

    // Drive the register-file port from the selected source.
    always_comb begin
        rf_write_enable = 1'b0;
        rf_rd_address   = '0;
        rf_rd_data      = '0;
        case (w_src)
            SRC_WB0: begin
                rf_write_enable = 1'b1;
                rf_rd_address   = wb0_rd;
                rf_rd_data      = wb0_data;
            end
            SRC_WB1: begin
                rf_write_enable = 1'b1;
                rf_rd_address   = wb1_rd;
                rf_rd_data      = wb1_data;
            end
            SRC_ISSUE: begin
                rf_write_enable = 1'b1;
                rf_rd_address   = issue_rd;
                rf_rd_data      = issue_data;
            end
            default: begin
                rf_write_enable = 1'b0;
            end
        endcase
    end

    // Busy bits: a set and a clear never target the same valid entry because
    // issue stalls on busy[rd].
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
        end
    end

    // Outstanding long-write counter; simultaneous set and clear cancel out.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pend_cnt <= '0;
        end else begin
            case ({w_long_set, w_clr})
                2'b10:   r_pend_cnt <= r_pend_cnt + CNT_W'(1);
                2'b01:   r_pend_cnt <= r_pend_cnt - CNT_W'(1);
                default: r_pend_cnt <= r_pend_cnt;
            endcase
        end
    end

    // Sticky error: a completion for a register nobody was waiting on.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_gnt_any && !w_gnt_rd_busy) begin
            r_err <= 1'b1;
        end
    end

    assign issue_ready    = w_ready;
    assign wb0_grant      = w_gnt0;
    assign wb1_grant      = w_gnt1;
    assign pending_count  = r_pend_cnt;
    assign protocol_error = r_err;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Scoreboard bench for regfile_wb_scheduler. A driver applies one input
// vector per cycle and queues the outputs a list-based reference model
// predicts; a monitor pops and compares them on the falling edge.
module tb_regfile_wb_scheduler;

    localparam int MAXP = 4;
    localparam int CW   = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic [4:0]  issue_rs1, issue_rs2, issue_rd;
    logic        issue_rd_we, issue_long;
    logic [31:0] issue_data;
    logic        issue_ready;
    logic        wb0_valid, wb1_valid;
    logic [4:0]  wb0_rd, wb1_rd;
    logic [31:0] wb0_data, wb1_data;
    logic        wb0_grant, wb1_grant;
    logic        rf_write_enable;
    logic [4:0]  rf_rd_address;
    logic [31:0] rf_rd_data;
    logic [CW-1:0] pending_count;
    logic        protocol_error;

    always #5 clock = ~clock;

    regfile_wb_scheduler #(.MAX_PENDING(MAXP), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset),
        .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rd(issue_rd), .issue_rd_we(issue_rd_we), .issue_long(issue_long),
        .issue_data(issue_data), .issue_ready(issue_ready),
        .wb0_valid(wb0_valid), .wb0_rd(wb0_rd), .wb0_data(wb0_data), .wb0_grant(wb0_grant),
        .wb1_valid(wb1_valid), .wb1_rd(wb1_rd), .wb1_data(wb1_data), .wb1_grant(wb1_grant),
        .rf_write_enable(rf_write_enable), .rf_rd_address(rf_rd_address),
        .rf_rd_data(rf_rd_data), .pending_count(pending_count),
        .protocol_error(protocol_error)
    );

    typedef struct packed {
        logic          ready;
        logic          g0;
        logic          g1;
        logic          we;
        logic [4:0]    addr;
        logic [31:0]   data;
        logic [CW-1:0] cnt;
        logic          err;
    } exp_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;

    // Reference model: the set of registers awaiting a long result, who won
    // the port last, and the sticky error.
    int   pend_q[$];
    int   last_winner;
    bit   m_err;

    // Behaviour of the two long-latency units: results they still owe.
    wb_t  uq0[$];
    wb_t  uq1[$];
    bit   act0, act1;

    function automatic bit is_busy(int r);
        foreach (pend_q[i]) if (pend_q[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void drop(int r);
        for (int i = 0; i < pend_q.size(); i++) begin
            if (pend_q[i] == r) begin
                pend_q.delete(i);
                return;
            end
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every predicted output vector against the DUT.
    always @(negedge clock) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("issue_ready",     32'(issue_ready),     32'(mon_e.ready));
            chk("wb0_grant",       32'(wb0_grant),       32'(mon_e.g0));
            chk("wb1_grant",       32'(wb1_grant),       32'(mon_e.g1));
            chk("rf_write_enable", 32'(rf_write_enable), 32'(mon_e.we));
            chk("rf_rd_address",   32'(rf_rd_address),   32'(mon_e.addr));
            chk("rf_rd_data",      rf_rd_data,           mon_e.data);
            chk("pending_count",   32'(pending_count),   32'(mon_e.cnt));
            chk("protocol_error",  32'(protocol_error),  32'(mon_e.err));
        end
    end

    // One cycle: drive inputs, predict outputs, advance the model.
    task automatic step(input bit r_in, input bit v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input bit we, input bit lng, input logic [31:0] d,
                        input bit on, input bit frc);
        exp_t e;
        bit w0v, w1v, g0, g1, stall, ready;
        logic [4:0]  grd;
        logic [31:0] gdat;
        @(posedge clock);
        #1;
        w0v = on && (uq0.size() > 0) && (frc || act0 || ($urandom_range(0, 1) == 1));
        w1v = on && (uq1.size() > 0) && (frc || act1 || ($urandom_range(0, 1) == 1));
        if (w0v) act0 = 1'b1;
        if (w1v) act1 = 1'b1;
        reset       = r_in;
        wb0_valid   = w0v;
        wb0_rd      = w0v ? uq0[0].rd : 5'd0;
        wb0_data    = w0v ? uq0[0].data : 32'd0;
        wb1_valid   = w1v;
        wb1_rd      = w1v ? uq1[0].rd : 5'd0;
        wb1_data    = w1v ? uq1[0].data : 32'd0;
        issue_valid = v;
        issue_rs1   = rs1;
        issue_rs2   = rs2;
        issue_rd    = rd;
        issue_rd_we = we;
        issue_long  = lng;
        issue_data  = d;
        e = '0;
        if (r_in) begin
            pend_q.delete();
            uq0.delete();
            uq1.delete();
            act0 = 1'b0;
            act1 = 1'b0;
            last_winner = 1;
            m_err = 1'b0;
            exp_q.push_back(e);
            return;
        end
        g0 = w0v && (!w1v || last_winner == 1);
        g1 = w1v && !g0;
        grd  = g0 ? wb0_rd : wb1_rd;
        gdat = g0 ? wb0_data : wb1_data;
        stall = is_busy(int'(rs1)) || is_busy(int'(rs2)) || (we && is_busy(int'(rd)))
             || (lng && we && rd != 0 && pend_q.size() == MAXP)
             || ((w0v || w1v) && we && !lng);
        ready = v && !stall;
        e.ready = ready;
        e.g0    = g0;
        e.g1    = g1;
        if (g0 || g1) begin
            e.we = 1'b1; e.addr = grd; e.data = gdat;
        end else if (ready && we && !lng && rd != 0) begin
            e.we = 1'b1; e.addr = rd; e.data = d;
        end
        e.cnt = CW'(pend_q.size());
        e.err = m_err;
        exp_q.push_back(e);
        if (g0 || g1) begin
            if (is_busy(int'(grd))) drop(int'(grd));
            else m_err = 1'b1;
            last_winner = g1 ? 1 : 0;
            if (g0) begin void'(uq0.pop_front()); act0 = 1'b0; end
            else    begin void'(uq1.pop_front()); act1 = 1'b0; end
        end
        if (ready && lng && we && rd != 0) begin
            pend_q.push_back(int'(rd));
            if (rd[0]) uq0.push_back('{rd: rd, data: $urandom});
            else       uq1.push_back('{rd: rd, data: $urandom});
        end
    endtask

    task automatic idle(input bit on, input bit frc);
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0, on, frc);
    endtask

    task automatic long_op(input logic [4:0] rd, input bit on);
        step(1'b0, 1'b1, 5'd0, 5'd0, rd, 1'b1, 1'b1, $urandom, on, 1'b1);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (uq0.size() > 0 || uq1.size() > 0); i++) idle(1'b1, 1'b1);
        tests++;
        if (uq0.size() > 0 || uq1.size() > 0) begin
            fails++;
            $display("FAIL drain: units still owe %0d results, required 0", uq0.size() + uq1.size());
        end
    endtask

    initial begin
        reset = 1'b1;
        issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
        issue_rd_we = 0; issue_long = 0; issue_data = 0;
        wb0_valid = 0; wb0_rd = 0; wb0_data = 0;
        wb1_valid = 0; wb1_rd = 0; wb1_data = 0;
        last_winner = 1; m_err = 0; act0 = 0; act1 = 0;

        step(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1'b0, 1'b0);

        // Short op writes through in the same cycle.
        step(1'b0, 1, 5'd1, 5'd2, 5'd5, 1, 0, 32'hDEADBEEF, 0, 0);

        // RAW on a long op: stall until its completion has landed.
        long_op(5'd7, 1'b0);
        step(1'b0, 1, 5'd7, 5'd0, 5'd10, 1, 0, 32'h11, 0, 0);
        step(1'b0, 1, 5'd7, 5'd0, 5'd10, 1, 0, 32'h11, 1, 1);
        step(1'b0, 1, 5'd7, 5'd0, 5'd10, 1, 0, 32'h11, 1, 1);

        // Both units contending while a short write waits.
        long_op(5'd3, 1'b0);
        long_op(5'd4, 1'b0);
        long_op(5'd8, 1'b0);
        long_op(5'd9, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1, 5'd0, 5'd0, 5'd20, 1, 0, 32'h2020, 1, 1);
        drain();

        // Pending limit: the fifth long op waits for a grant.
        for (int r = 1; r <= 5; r++) long_op(5'(r), 1'b0);
        for (int i = 0; i < 3; i++) long_op(5'd5, 1'b1);
        drain();

        // x0 long op and a stray completion.
        long_op(5'd0, 1'b0);
        uq1.push_back('{rd: 5'd12, data: 32'h12345678});
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b1);
        idle(1'b0, 1'b0);

        // Reset with three pending writes and a completion requesting.
        long_op(5'd1, 1'b0);
        long_op(5'd3, 1'b0);
        long_op(5'd5, 1'b0);
        step(1'b1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        step(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1'b0, 1, 5'd3, 5'd5, 5'd6, 1, 0, 32'hCAFE0006, 0, 0);
        idle(1'b0, 1'b0);

        // Randomised traffic over a small register window to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            step(1'b0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)),
                 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 $urandom, 1'b1, 1'b0);
        end
        drain();
        idle(1'b0, 1'b0);

        @(negedge clock);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL leftover: %0d predictions unchecked, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
